uart_rx: RTL and testbench
==========================

# uart_rx

Serial receive half of the AXI-Lite UART controller. It deserializes one asynchronous UART frame from `rx`: start bit, 8 data bits (LSB first), optional parity bit and stop bit. It samples against a 16x-oversampling `b_tick` enable from the shared baud generator. Each received byte is presented on `dout` with a one-clock `rx_done` strobe, which the RX FIFO uses as its write enable.

## Interface
- `DBIT`, 8 — data bits per frame.
- `SB_TICK`, 16 — `b_tick` count for the stop bit (16 = 1 stop bit).
- `clk`  in  1  — system clock; all logic rising-edge.
- `a_resetn`  in  1  — synchronous, active-high reset (despite the name); sampled on `clk`.
- `rx`  in  1  — serial line, idle high, asynchronous to `clk`.
- `b_tick`  in  1  — one-`clk` enable pulse at 16x baud rate.
- `parity`  in  2  — 00 none, 01 odd, 10 even, 11 none; sampled at start-bit detection and held for the frame.
- `rx_done`  out  1  — one-`clk` pulse when a frame completes.
- `dout`  out  DBIT  — last received byte; holds until the next `rx_done`.
- `parity_err`  out  1  — valid with `rx_done`; high if the parity check failed. Always 0 when parity is disabled.
- `frame_err`  out  1  — valid with `rx_done`; high if the stop-bit sample was 0.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1. All sampling uses the synchronized `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP. Registers:
  - tick counter `s` (4 bit)
  - bit counter `n` (3 bit)
  - shift register `b` (DBIT)
  - latched parity mode
  - parity accumulator
- Counters advance only on clocks where `b_tick`=1.
- IDLE: when `rx_s`=0, clear `s`, latch the parity mode and go to START.
- START: on the tick where `s`==7 (mid start bit):
  - if `rx_s`=0, clear `s` and `n` and go to DATA;
  - if `rx_s`=1, treat it as a glitch and return to IDLE with no output.
- DATA: on `s`==15, sample `rx_s` into `b` MSB and shift right (LSB arrives first), toggle the accumulator, clear `s`. After `n`==DBIT-1, go to PARITY if enabled, else STOP.
- PARITY: on `s`==15, sample the parity bit and clear `s`, then go to STOP.
  - Odd mode: error if the data ones count plus the parity bit is even.
  - Even mode: error if that total is odd.
- STOP: on `s`==SB_TICK-1, sample the stop bit, then in the same clock:
  - pulse `rx_done`, load `dout`<=`b`, update `parity_err` and `frame_err`;
  - return to IDLE.
- The byte is delivered even on error; the flags only qualify it.
- No lost-data handling. The FIFO consumes `rx_done` every frame.

## Timing
- Reset values: state IDLE, `s`=`n`=0, `b`=0, `dout`=0, `rx_done`=0, `parity_err`=0, `frame_err`=0, synchronizer flops=1.
- Reset mid-frame aborts the frame on the next clock, with no `rx_done`.
- Detection latency: 2 clks (synchronizer) plus up to one `b_tick` period.
- Each data, parity and stop bit is sampled 16 ticks after the previous sample, i.e. mid-bit.
- `rx_done` lasts exactly 1 clk, registered, on the clock of the final stop tick.
- `dout`, `parity_err` and `frame_err` change only on that clock.
- Total frame length: 8 + 16·DBIT + 16·(parity enabled) + SB_TICK ticks from the start edge.
- Back-to-back frames: a new start edge may be accepted on the clock after STOP returns to IDLE.
- `parity` changes mid-frame have no effect on the current frame.

## Structure
- Shared package `uart_pkg`:
  - parity mode constants (PAR_NONE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10);
  - `rx_state_t` enum;
  - defaults for DBIT and SB_TICK, shared with `uart_tx` and the baud generator.
- One sub-module is natural: `sync_2ff` (reset value parameterized, here 1), reused for other asynchronous inputs.

## Test plan
- Reset: assert `a_resetn`=1 for several clks -> all outputs 0, no `rx_done` while `rx` idles high.
- Odd parity: `parity`=01, data bits LSB-first 0,1,1,0,0,1,1,1, parity bit 0, stop 1, 16 ticks per bit -> single `rx_done` pulse, `dout`=8'hE6, `parity_err`=0, `frame_err`=0.
- Even parity and no parity:
  - `parity`=10, byte 8'hE6, parity bit 1 -> `dout`=8'hE6, `parity_err`=0.
  - `parity`=00, no parity bit sent -> `rx_done` one bit-time earlier.
- Errors:
  - odd mode with parity bit 1 for 8'hE6 -> `dout`=8'hE6, `parity_err`=1;
  - stop bit driven 0 -> `frame_err`=1.
- Glitch: `rx` low for 4 ticks then high -> no `rx_done`, FSM back in IDLE; a following valid frame 8'h55 is received correctly.
- Reset mid-DATA, then send 8'hA3 -> no pulse for the aborted frame, exactly one `rx_done` with `dout`=8'hA3.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions: parity modes, RX state encoding and
//            default frame parameters used by uart_rx, uart_tx and baud gen.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Default frame geometry shared by both directions of the UART
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

  // Parity mode encodings (2'b11 is treated as "none")
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  // Receiver FSM state encoding
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // True when the mode carries a parity bit on the line
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for a single asynchronous input bit.
//            Both flops reset to RST_VAL so an idle line reads correctly
//            straight out of reset.
// Revision : 1.0  initial release
// ============================================================================
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops to settle metastability
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : UART receiver. Deserializes start, DBIT data bits (LSB first),
//            optional parity and stop bit using a 16x oversampling tick.
//            Each byte is presented on dout with a one-clock rx_done strobe.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic            clk,
  input  logic            a_resetn,   // active-high synchronous reset
  input  logic            rx,
  input  logic            b_tick,
  input  logic [1:0]      parity,
  output logic            rx_done,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err
);

  localparam logic [2:0] ST_IDLE   = 3'(RX_IDLE);
  localparam logic [2:0] ST_START  = 3'(RX_START);
  localparam logic [2:0] ST_DATA   = 3'(RX_DATA);
  localparam logic [2:0] ST_PARITY = 3'(RX_PARITY);
  localparam logic [2:0] ST_STOP   = 3'(RX_STOP);

  localparam logic [3:0] S_MID     = 4'd7;
  localparam logic [3:0] S_LAST    = 4'd15;
  localparam logic [3:0] S_STOP    = 4'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

  logic            rx_s;
  logic [2:0]      state;
  logic [3:0]      s;
  logic [2:0]      n;
  logic [DBIT-1:0] b;
  logic [1:0]      pmode;
  logic            acc;       // running XOR of the received data bits
  logic            par_bad;   // parity verdict held until the stop bit

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (a_resetn),
    .d   (rx),
    .q   (rx_s)
  );

  // Frame FSM: tick counting, bit sampling and result delivery
  always_ff @(posedge clk) begin
    if (a_resetn) begin
      state      <= ST_IDLE;
      s          <= 4'd0;
      n          <= 3'd0;
      b          <= '0;
      pmode      <= PAR_NONE;
      acc        <= 1'b0;
      par_bad    <= 1'b0;
      rx_done    <= 1'b0;
      dout       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Start-edge detection does not wait for a tick
          if (!rx_s) begin
            s     <= 4'd0;
            pmode <= parity;
            state <= ST_START;
          end
        end

        ST_START: begin
          if (b_tick) begin
            if (s == S_MID) begin
              if (!rx_s) begin
                s       <= 4'd0;
                n       <= 3'd0;
                acc     <= 1'b0;
                par_bad <= 1'b0;
                state   <= ST_DATA;
              end else begin
                // Line went high again before mid start bit: a glitch
                state <= ST_IDLE;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end

        ST_DATA: begin
          if (b_tick) begin
            if (s == S_LAST) begin
              s   <= 4'd0;
              b   <= {rx_s, b[DBIT-1:1]};
              acc <= acc ^ rx_s;
              if (n == N_LAST) begin
                state <= parity_enabled(pmode) ? ST_PARITY : ST_STOP;
              end else begin
                n <= n + 3'd1;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end

        ST_PARITY: begin
          if (b_tick) begin
            if (s == S_LAST) begin
              s <= 4'd0;
              // Odd mode wants an odd total of ones, even mode an even one
              if (pmode == PAR_ODD) begin
                par_bad <= ~(acc ^ rx_s);
              end else begin
                par_bad <= acc ^ rx_s;
              end
              state <= ST_STOP;
            end else begin
              s <= s + 4'd1;
            end
          end
        end

        ST_STOP: begin
          if (b_tick) begin
            if (s == S_STOP) begin
              s          <= 4'd0;
              rx_done    <= 1'b1;
              dout       <= b;
              parity_err <= par_bad;
              frame_err  <= ~rx_s;
              state      <= ST_IDLE;
            end else begin
              s <= s + 4'd1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. Frames are built bit by bit on
//            a 16-tick bit grid; a queue of expected deliveries (byte, flags
//            and the tick on which rx_done must fire) is checked every clock.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int TP  = 4;    // clocks per b_tick
  localparam int DB  = 8;
  localparam int SBT = 16;

  logic       clk = 1'b0;
  logic       a_resetn = 1'b1;
  logic       rx = 1'b1;
  logic       b_tick = 1'b0;
  logic [1:0] parity = 2'b00;
  logic       rx_done;
  logic [7:0] dout;
  logic       parity_err;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  int unsigned tick_cnt = 0;
  int ph = 0;

  typedef struct {
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
    int unsigned tick;
  } exp_t;

  exp_t expq[$];

  logic [7:0] held_dout = 8'h00;
  logic       held_perr = 1'b0;
  logic       held_ferr = 1'b0;
  logic [7:0] last_dout = 8'h00;
  logic       last_perr = 1'b0;
  logic       last_ferr = 1'b0;
  int         done_cnt  = 0;

  uart_rx #(
    .DBIT    (DB),
    .SB_TICK (SBT)
  ) dut (
    .clk        (clk),
    .a_resetn   (a_resetn),
    .rx         (rx),
    .b_tick     (b_tick),
    .parity     (parity),
    .rx_done    (rx_done),
    .dout       (dout),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Baud tick: one clock in every TP
  always @(negedge clk) begin
    ph = (ph + 1) % TP;
    b_tick = (ph == 0);
  end

  always @(posedge clk) tick_cnt <= tick_cnt + {31'b0, b_tick};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Parity error rule: odd mode wants an odd total, even mode an even total
  function automatic logic model_perr(input logic [7:0] d, input logic [1:0] pm, input logic pbit);
    int ones;
    ones = $countones(d) + int'(pbit);
    if (pm == 2'b01) return (ones % 2) == 0;
    if (pm == 2'b10) return (ones % 2) == 1;
    return 1'b0;
  endfunction

  function automatic logic good_pbit(input logic [7:0] d, input logic [1:0] pm);
    int ones;
    ones = $countones(d);
    if (pm == 2'b01) return (ones % 2) == 0;
    return (ones % 2) == 1;
  endfunction

  function automatic logic has_parity(input logic [1:0] pm);
    return (pm == 2'b01) || (pm == 2'b10);
  endfunction

  function automatic int frame_ticks(input logic [1:0] pm);
    return 8 + 16 * DB + (has_parity(pm) ? 16 : 0) + SBT;
  endfunction

  // Compare DUT outputs against the expectation queue on every clock
  always @(negedge clk) begin
    exp_t e;
    if (a_resetn) begin
      held_dout = 8'h00;
      held_perr = 1'b0;
      held_ferr = 1'b0;
    end else if (rx_done === 1'b1) begin
      done_cnt++;
      last_dout = dout;
      last_perr = parity_err;
      last_ferr = frame_err;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rx_done: got dout %0h, required no pulse (t=%0t)", dout, $time);
      end else begin
        e = expq.pop_front();
        check("dout", 32'(dout), 32'(e.data));
        check("parity_err", 32'(parity_err), 32'(e.perr));
        check("frame_err", 32'(frame_err), 32'(e.ferr));
        check("done_tick", tick_cnt, e.tick);
        held_dout = e.data;
        held_perr = e.perr;
        held_ferr = e.ferr;
      end
    end else begin
      check("rx_done_low", 32'(rx_done), 32'd0);
      check("dout_hold", 32'(dout), 32'(held_dout));
      check("perr_hold", 32'(parity_err), 32'(held_perr));
      check("ferr_hold", 32'(frame_err), 32'(held_ferr));
      if (expq.size() > 0 && tick_cnt > expq[0].tick) begin
        checks++;
        errors++;
        $display("FAIL missed_rx_done: got none by tick %0d, required at tick %0d", tick_cnt, expq[0].tick);
        void'(expq.pop_front());
      end
    end
  end

  task automatic wait_ticks(input int nt);
    repeat (nt) begin
      do @(posedge clk); while (b_tick !== 1'b1);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic flip_p,
                            input logic stop_bit, input int gap);
    exp_t e;
    logic pb;
    pb = good_pbit(d, pm) ^ flip_p;
    wait_ticks(1);
    parity = pm;
    e.data = d;
    e.perr = has_parity(pm) ? model_perr(d, pm, pb) : 1'b0;
    e.ferr = ~stop_bit;
    e.tick = tick_cnt + frame_ticks(pm);
    expq.push_back(e);
    rx = 1'b0;
    wait_ticks(1);
    parity = 2'($urandom);     // must not affect the frame in flight
    wait_ticks(15);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    if (has_parity(pm)) begin
      rx = pb;
      wait_ticks(16);
    end
    rx = stop_bit;
    if (stop_bit) begin
      wait_ticks(SBT);
    end else begin
      wait_ticks(9);
      rx = 1'b1;
      wait_ticks(16);
    end
    rx = 1'b1;
    wait_ticks(gap);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;

    // Model pins
    check("model_odd_ok", 32'(model_perr(8'hE6, 2'b01, 1'b0)), 32'd0);
    check("model_odd_bad", 32'(model_perr(8'hE6, 2'b01, 1'b1)), 32'd1);
    check("model_even_ok", 32'(model_perr(8'hE6, 2'b10, 1'b1)), 32'd0);
    check("len_parity", 32'(frame_ticks(2'b01)), 32'd168);
    check("len_none", 32'(frame_ticks(2'b00)), 32'd152);

    // Reset
    a_resetn = 1'b1;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_rx_done", 32'(rx_done), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    a_resetn = 1'b0;
    wait_ticks(10);
    check("idle_no_done", 32'(done_cnt), 32'd0);

    // Odd parity, E6, correct parity bit 0
    d0 = done_cnt;
    send_frame(8'hE6, 2'b01, 1'b0, 1'b1, 4);
    check("odd_count", 32'(done_cnt - d0), 32'd1);
    check("odd_dout", 32'(last_dout), 32'hE6);
    check("odd_perr", 32'(last_perr), 32'd0);
    check("odd_ferr", 32'(last_ferr), 32'd0);

    // Even parity, E6, parity bit 1
    send_frame(8'hE6, 2'b10, 1'b0, 1'b1, 4);
    check("even_dout", 32'(last_dout), 32'hE6);
    check("even_perr", 32'(last_perr), 32'd0);

    // No parity
    send_frame(8'h3C, 2'b00, 1'b0, 1'b1, 4);
    check("none_dout", 32'(last_dout), 32'h3C);

    // Odd parity with wrong parity bit
    send_frame(8'hE6, 2'b01, 1'b1, 1'b1, 4);
    check("perr_dout", 32'(last_dout), 32'hE6);
    check("perr_flag", 32'(last_perr), 32'd1);

    // Stop bit low
    send_frame(8'h81, 2'b00, 1'b0, 1'b0, 4);
    check("ferr_dout", 32'(last_dout), 32'h81);
    check("ferr_flag", 32'(last_ferr), 32'd1);

    // Glitch then valid 55
    d0 = done_cnt;
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(12);
    check("glitch_no_done", 32'(done_cnt - d0), 32'd0);
    send_frame(8'h55, 2'b00, 1'b0, 1'b1, 4);
    check("after_glitch_count", 32'(done_cnt - d0), 32'd1);
    check("after_glitch_dout", 32'(last_dout), 32'h55);

    // Reset in the middle of DATA, then A3
    d0 = done_cnt;
    wait_ticks(1);
    parity = 2'b00;
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(16);
    rx = 1'b0;
    wait_ticks(16);
    a_resetn = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_done", 32'(rx_done), 32'd0);
    a_resetn = 1'b0;
    wait_ticks(200);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    send_frame(8'hA3, 2'b00, 1'b0, 1'b1, 4);
    check("a3_count", 32'(done_cnt - d0), 32'd1);
    check("a3_dout", 32'(last_dout), 32'hA3);

    // Randomized frames
    for (int k = 0; k < 30; k++) begin
      send_frame(8'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) != 0), int'($urandom_range(0, 6)));
    end

    wait_ticks(20);
    check("queue_empty", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
